serial_rx_sequencer: RTL and testbench
======================================

Name: serial_rx_sequencer

Overview:
Control FSM that sequences the 8-bit serial shift-register/bit-counter datapath to receive one framed byte. It detects the start bit on the serial line and drives the datapath's register/counter init, shift-enable and increment strobes. It checks the optional parity bit and the stop bit, then presents the received byte with a valid/ack handshake. It also keeps sticky error flags and a good-frame counter. It sits between the serial input pin and the byte consumer, alongside the datapath instance.

Parameters:
PARITY_EN, 1, 1 = a parity bit follows the 8 data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity (data bits plus parity bit have an even number of 1s); 1 = odd parity.
CNT_W, 8, width of the good-frame counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
serI  input  1  serial line, one bit per clk, LSB first, idles high
Co  input  1  datapath bit-counter carry; high when the counter equals 7
data_ack  input  1  consumer has taken the byte (sampled only while data_valid = 1)
err_clr  input  1  clears frame_err, parity_err and overrun
en_reg  output  1  datapath shift enable
Init_reg  output  1  datapath shift-register clear
Init_cnt  output  1  datapath bit-counter clear
Inc_cnt  output  1  datapath bit-counter increment
busy  output  1  high whenever state != IDLE
data_valid  output  1  datapath reg_out holds a good byte
frame_err  output  1  sticky flag: stop bit sampled 0
parity_err  output  1  sticky flag: parity mismatch
overrun  output  1  sticky flag: new frame accepted while data_valid = 1 and not acked
good_cnt  output  CNT_W  count of good frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE. All outputs = 0, good_cnt = 0, internal parity accumulator = 0. A reset mid-frame abandons the frame with no flag set. The next start bit re-inits the datapath.
- States: IDLE, DATA, PAR, STOP. Datapath strobes are combinational from state and serI. All flags and counters are registered.
- IDLE: if serI = 0 (start bit), assert Init_reg = Init_cnt = 1 in the same cycle, clear the parity accumulator, and go to DATA. Otherwise stay in IDLE with all strobes at 0.
- DATA: en_reg = Inc_cnt = 1 every cycle, and the parity accumulator XORs in serI. When Co = 1 (8th data bit is being shifted), go to PAR if PARITY_EN = 1, else go to STOP. The datapath counter wraps to 0 on that increment. DATA always lasts exactly 8 cycles.
- PAR: all strobes 0. Compute expected parity bit = accumulator XOR PARITY_ODD. If serI differs from the expected bit, set the pending-parity-error bit. Go to STOP.
- STOP: all strobes 0.
  - serI = 1 and no pending parity error: set data_valid and increment good_cnt.
  - serI = 0: set frame_err.
  - Pending parity error: set parity_err. It can be set together with frame_err.
  - Always go to IDLE. The stop cycle is never interpreted as a start bit.
- Latency: start bit at cycle 0 gives data_valid high after the edge ending cycle 10 (parity enabled) or cycle 9 (parity disabled).
- data_valid clear conditions:
  - data_ack = 1 while data_valid = 1: clears data_valid at the next edge.
  - A new start bit accepted in IDLE: clears data_valid, because Init_reg destroys the byte. If data_valid = 1 and data_ack = 0 in that cycle, also set overrun. Ack and start in the same cycle: no overrun.
- reg_out is unchanged between STOP and the next start, so the byte is stable for as long as data_valid = 1.
- err_clr = 1 clears all three sticky flags at the next edge. If a flag-set event occurs in the same cycle, set wins.
- good_cnt wraps from 2^CNT_W - 1 to 0 with no flag.
- data_ack while data_valid = 0 is ignored.

Test Plan:
- Good frame, 0xA5, even parity: serI = 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Required: Init strobes in cycle 0; en_reg/Inc_cnt high in cycles 1–8; data_valid = 1 after cycle 10; reg_out = 0xA5; good_cnt = 1; no flags.
- Parity error: same frame with parity bit 1. Required: parity_err = 1, data_valid = 0, good_cnt unchanged. Pulse err_clr -> parity_err = 0 on the next cycle.
- Framing error: 0x3C with correct parity and stop bit 0. Required: frame_err = 1, data_valid = 0, state returns to IDLE. A start bit in the following cycle is accepted normally.
- Overrun and simultaneous ack: first, receive 0x11 with no ack, then start 0x22. Required: overrun = 1, data_valid drops at the start, then rises again with 0x22. Second, repeat with data_ack in the start cycle. Required: overrun stays 0.
- Reset mid-frame: assert rst = 0 during data bit 4. Required: busy, data_valid, all flags, good_cnt and strobes all 0 immediately. A full frame 0xFF after release is received correctly.
- PARITY_EN = 0 and CNT_W = 2: send 5 good frames. Required: data_valid after cycle 9 each time; good_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/serial_rx_sequencer.sv
// Receive-side control FSM for one framed serial byte: start detect, 8 data bits,
// optional parity, stop check, valid/ack handshake, sticky error flags and good-frame count.
module serial_rx_sequencer #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serI,
    input  logic             Co,
    input  logic             data_ack,
    input  logic             err_clr,
    output logic             en_reg,
    output logic             Init_reg,
    output logic             Init_cnt,
    output logic             Inc_cnt,
    output logic             busy,
    output logic             data_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic [CNT_W-1:0] good_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             w_start;
    logic             w_shift;
    logic             w_in_par;
    logic             w_in_stop;
    logic             w_good;
    logic             w_par_bad;

    logic             r_par_acc;
    logic             r_par_pend;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_good_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DATA exits on the counter carry, so its length is set by the datapath counter.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (!serI) begin
                    w_start = 1'b1;
                    w_next  = DATA;
                end
            end
            DATA: begin
                w_shift = 1'b1;
                if (Co) begin
                    w_next = PARITY_EN ? PAR : STOP;
                end
            end
            PAR:     w_next = STOP;
            STOP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_in_par  = (r_state == PAR);
    assign w_in_stop = (r_state == STOP);
    assign w_par_bad = serI ^ (r_par_acc ^ PARITY_ODD);
    assign w_good    = w_in_stop & serI & ~r_par_pend;

    // Strobes are gated by reset so nothing reaches the datapath while rst is held low.
    assign Init_reg = w_start & rst;
    assign Init_cnt = w_start & rst;
    assign en_reg   = w_shift & rst;
    assign Inc_cnt  = w_shift & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_acc  <= 1'b0;
            r_par_pend <= 1'b0;
        end else if (w_start) begin
            r_par_acc  <= 1'b0;
            r_par_pend <= 1'b0;
        end else if (w_shift) begin
            r_par_acc  <= r_par_acc ^ serI;
        end else if (w_in_par) begin
            r_par_pend <= w_par_bad;
        end
    end

    // A start destroys the held byte, so it clears valid ahead of any ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_valid <= 1'b0;
        end else if (w_start) begin
            r_data_valid <= 1'b0;
        end else if (w_good) begin
            r_data_valid <= 1'b1;
        end else if (data_ack) begin
            r_data_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_in_stop && !serI) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_in_stop && r_par_pend) begin
                r_parity_err <= 1'b1;
            end else if (err_clr) begin
                r_parity_err <= 1'b0;
            end
            if (w_start && r_data_valid && !data_ack) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_good_cnt <= '0;
        end else if (w_good) begin
            r_good_cnt <= r_good_cnt + CNT_W'(1);
        end
    end

    assign busy       = (r_state != IDLE);
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign good_cnt   = r_good_cnt;

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Directed bench: two sequencer instances (parity on / 8-bit count, parity off / 2-bit count),
// each paired with a small shift-register/bit-counter datapath model.
module tb_serial_rx_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ser = 1'b1;
    logic data_ack = 1'b0;
    logic err_clr = 1'b0;
    logic use_b = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: parity enabled, even parity, 8-bit counter
    logic       ser_a, ack_a, clr_a, co_a;
    logic       en_a, ireg_a, icnt_a, inc_a, busy_a, dv_a, ferr_a, perr_a, ovr_a;
    logic [7:0] cnt_a;
    // Instance B: no parity, 2-bit counter
    logic       ser_b, ack_b, clr_b, co_b;
    logic       en_b, ireg_b, icnt_b, inc_b, busy_b, dv_b, ferr_b, perr_b, ovr_b;
    logic [1:0] cnt_b;

    assign ser_a = use_b ? 1'b1 : ser;
    assign ack_a = use_b ? 1'b0 : data_ack;
    assign clr_a = use_b ? 1'b0 : err_clr;
    assign ser_b = use_b ? ser : 1'b1;
    assign ack_b = use_b ? data_ack : 1'b0;
    assign clr_b = use_b ? err_clr : 1'b0;

    serial_rx_sequencer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .serI(ser_a), .Co(co_a), .data_ack(ack_a), .err_clr(clr_a),
        .en_reg(en_a), .Init_reg(ireg_a), .Init_cnt(icnt_a), .Inc_cnt(inc_a), .busy(busy_a),
        .data_valid(dv_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
        .good_cnt(cnt_a)
    );

    serial_rx_sequencer #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .serI(ser_b), .Co(co_b), .data_ack(ack_b), .err_clr(clr_b),
        .en_reg(en_b), .Init_reg(ireg_b), .Init_cnt(icnt_b), .Inc_cnt(inc_b), .busy(busy_b),
        .data_valid(dv_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
        .good_cnt(cnt_b)
    );

    // Datapath models: LSB-first shift register and 3-bit counter with carry at 7
    logic [7:0] sr_a, sr_b;
    logic [2:0] bc_a, bc_b;
    assign co_a = (bc_a == 3'd7);
    assign co_b = (bc_b == 3'd7);

    always @(posedge clk) begin
        if (ireg_a) sr_a <= 8'h00;
        else if (en_a) sr_a <= {ser_a, sr_a[7:1]};
        if (icnt_a) bc_a <= 3'd0;
        else if (inc_a) bc_a <= bc_a + 3'd1;
        if (ireg_b) sr_b <= 8'h00;
        else if (en_b) sr_b <= {ser_b, sr_b[7:1]};
        if (icnt_b) bc_b <= 3'd0;
        else if (inc_b) bc_b <= bc_b + 3'd1;
    end

    // Observation muxes for whichever instance is under test
    logic        o_en, o_ireg, o_icnt, o_inc, o_busy, o_dv, o_ferr, o_perr, o_ovr;
    logic [31:0] o_cnt, o_sr;
    assign o_en   = use_b ? en_b   : en_a;
    assign o_ireg = use_b ? ireg_b : ireg_a;
    assign o_icnt = use_b ? icnt_b : icnt_a;
    assign o_inc  = use_b ? inc_b  : inc_a;
    assign o_busy = use_b ? busy_b : busy_a;
    assign o_dv   = use_b ? dv_b   : dv_a;
    assign o_ferr = use_b ? ferr_b : ferr_a;
    assign o_perr = use_b ? perr_b : perr_a;
    assign o_ovr  = use_b ? ovr_b  : ovr_a;
    assign o_cnt  = use_b ? 32'(cnt_b) : 32'(cnt_a);
    assign o_sr   = use_b ? 32'(sr_b)  : 32'(sr_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack, input logic clr);
        for (int k = 0; k < n; k++) begin
            ser      = 1'b1;
            data_ack = ack;
            err_clr  = clr;
            tick();
        end
        data_ack = 1'b0;
        err_clr  = 1'b0;
    endtask

    // Drives one frame from the start bit through the stop bit; returns data_valid seen
    // just after the start-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic ack0, output logic dv_after_start);
        int strobe_cycles;
        ser      = 1'b0;
        data_ack = ack0;
        #1;
        chk("start_strobes", {30'd0, o_ireg, o_icnt}, 32'h3);
        tick();
        dv_after_start = o_dv;
        data_ack = 1'b0;
        strobe_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            ser = d[i];
            #1;
            if (o_en && o_inc && !o_ireg) strobe_cycles++;
            tick();
        end
        chk("data_strobe_cycles", 32'(strobe_cycles), 32'd8);
        if (!use_b) begin
            ser = par;
            #1;
            chk("par_strobes", {29'd0, o_en, o_inc, o_ireg}, 32'd0);
            tick();
        end
        chk("dv_before_stop", {31'd0, o_dv}, 32'd0);
        ser = stp;
        #1;
        chk("busy_in_stop", {31'd0, o_busy}, 32'd1);
        tick();
        ser = 1'b1;
        $display("frame inst=%s data=%02h par=%b stop=%b ack0=%b -> dv=%b cnt=%0d fe=%b pe=%b ov=%b",
                 use_b ? "B" : "A", d, par, stp, ack0, o_dv, o_cnt, o_ferr, o_perr, o_ovr);
    endtask

    logic dvs;
    logic [7:0] b_data [5];
    logic [1:0] b_cnt  [5];

    initial begin
        b_data[0] = 8'h01; b_data[1] = 8'h80; b_data[2] = 8'hC3;
        b_data[3] = 8'h7E; b_data[4] = 8'h96;
        b_cnt[0] = 2'd1; b_cnt[1] = 2'd2; b_cnt[2] = 2'd3; b_cnt[3] = 2'd0; b_cnt[4] = 2'd1;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_flags", {28'd0, o_dv, o_ferr, o_perr, o_ovr}, 32'd0);
        chk("rst_cnt", o_cnt, 32'd0);
        rst = 1'b1;
        idle(2, 1'b0, 1'b0);

        // Good frame 0xA5, even parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, dvs);
        chk("a5_dv", {31'd0, o_dv}, 32'd1);
        chk("a5_byte", o_sr, 32'hA5);
        chk("a5_cnt", o_cnt, 32'd1);
        chk("a5_flags", {29'd0, o_ferr, o_perr, o_ovr}, 32'd0);
        idle(1, 1'b1, 1'b0);
        chk("a5_ack", {31'd0, o_dv}, 32'd0);

        // Parity error then clear
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, dvs);
        chk("perr_set", {31'd0, o_perr}, 32'd1);
        chk("perr_dv", {31'd0, o_dv}, 32'd0);
        chk("perr_cnt", o_cnt, 32'd1);
        idle(1, 1'b0, 1'b1);
        chk("perr_clr", {31'd0, o_perr}, 32'd0);

        // Framing error, then an immediate start accepted normally
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, dvs);
        chk("ferr_set", {31'd0, o_ferr}, 32'd1);
        chk("ferr_dv", {31'd0, o_dv}, 32'd0);
        chk("ferr_idle", {31'd0, o_busy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, dvs);
        chk("after_ferr_dv", {31'd0, o_dv}, 32'd1);
        chk("after_ferr_byte", o_sr, 32'h3C);
        chk("after_ferr_cnt", o_cnt, 32'd2);
        idle(1, 1'b1, 1'b0);

        // Overrun: 0x11 unacked then 0x22
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, dvs);
        chk("b11_dv", {31'd0, o_dv}, 32'd1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, dvs);
        chk("ovr_dv_drop", {31'd0, dvs}, 32'd0);
        chk("ovr_set", {31'd0, o_ovr}, 32'd1);
        chk("b22_dv", {31'd0, o_dv}, 32'd1);
        chk("b22_byte", o_sr, 32'h22);
        chk("b22_cnt", o_cnt, 32'd4);
        idle(1, 1'b0, 1'b1);
        chk("clr_all", {29'd0, o_ferr, o_perr, o_ovr}, 32'd0);
        chk("clr_keeps_dv", {31'd0, o_dv}, 32'd1);
        // Ack in the start cycle: no overrun
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, dvs);
        chk("ack_start_no_ovr", {31'd0, o_ovr}, 32'd0);
        chk("b33_dv", {31'd0, o_dv}, 32'd1);
        chk("b33_cnt", o_cnt, 32'd5);

        // Reset during data bit 4 of a frame whose start overruns the held 0x33
        ser = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            ser = 1'b1;
            tick();
        end
        chk("pre_rst_ovr", {31'd0, o_ovr}, 32'd1);
        ser = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_busy_dv", {30'd0, o_busy, o_dv}, 32'd0);
        chk("midrst_flags", {29'd0, o_ferr, o_perr, o_ovr}, 32'd0);
        chk("midrst_cnt", o_cnt, 32'd0);
        chk("midrst_strobes", {28'd0, o_en, o_inc, o_ireg, o_icnt}, 32'd0);
        tick();
        ser = 1'b1;
        rst = 1'b1;
        idle(2, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, dvs);
        chk("ff_dv", {31'd0, o_dv}, 32'd1);
        chk("ff_byte", o_sr, 32'hFF);
        chk("ff_cnt", o_cnt, 32'd1);
        chk("ff_flags", {29'd0, o_ferr, o_perr, o_ovr}, 32'd0);

        // Parity disabled, 2-bit counter wraps
        use_b = 1'b1;
        idle(2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            send_frame(b_data[k], 1'b0, 1'b1, 1'b1, dvs);
            chk("nopar_dv", {31'd0, o_dv}, 32'd1);
            chk("nopar_byte", o_sr, 32'(b_data[k]));
            chk("nopar_cnt", o_cnt, 32'(b_cnt[k]));
        end
        chk("nopar_flags", {29'd0, o_ferr, o_perr, o_ovr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
